// File: rtl/flag_seek_pkg.sv
// Shared types for the flag-index seek driver: FSM states and counter command selects.
package flag_seek_pkg;

    localparam int IDX_W_DEF = 7;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        FINISH
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        CLR,
        INC,
        DEC,
        LOAD
    } cmd_t;

endpackage

// File: rtl/flag_seek_dir.sv
// Ring distance from shadow to target on a counter of span max+1; picks the shorter
// direction (ties go forward) and whether that distance is small enough to step.
module flag_seek_dir
    import flag_seek_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int STEP_LIMIT = 4
) (
    input  logic [IDX_W-1:0] shadow,
    input  logic [IDX_W-1:0] target,
    input  logic [IDX_W-1:0] max_index,
    output logic             use_step,
    output logic             dir_inc
);

    logic [IDX_W:0] span;
    logic [IDX_W:0] fwd;
    logic [IDX_W:0] back;

    always_comb begin
        span = {1'b0, max_index} + (IDX_W+1)'(1);
        if (target >= shadow)
            fwd = {1'b0, target} - {1'b0, shadow};
        else
            fwd = {1'b0, target} + span - {1'b0, shadow};
        back     = span - fwd;
        dir_inc  = (fwd <= back);
        use_step = ((dir_inc ? fwd : back) <= (IDX_W+1)'(STEP_LIMIT));
    end

endmodule

// File: rtl/flag_seek_driver.sv
// Drives a downstream flag-index counter to a requested index with clr/inc/dec/load strobes.
// Define FLAG_SEEK_STEP_EN to serve short seeks with inc/dec strobes instead of a load.
module flag_seek_driver
    import flag_seek_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int GAP_CYCLES = 1,
    parameter int STEP_LIMIT = 4
) (
    input  logic             counter_clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_index,
    input  logic [IDX_W-1:0] max_index,
    output logic             cmd_clr,
    output logic             cmd_inc,
    output logic             cmd_dec,
    output logic             cmd_load,
    output logic [IDX_W-1:0] load_val,
    output logic [IDX_W-1:0] shadow,
    output logic             done,
    output logic             err
);

    localparam int GAP_W = 4;

    state_t           state;
    cmd_t             cmd;
    cmd_t             plan;
    cmd_t             fire;
    logic [IDX_W-1:0] max_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] shadow_nxt;

`ifdef FLAG_SEEK_STEP_EN
    logic use_step;
    logic dir_inc;

    flag_seek_dir #(
        .IDX_W      (IDX_W),
        .STEP_LIMIT (STEP_LIMIT)
    ) u_dir (
        .shadow    (shadow),
        .target    (req_index),
        .max_index (max_index),
        .use_step  (use_step),
        .dir_inc   (dir_inc)
    );

    always_comb begin
        if (req_index == '0)
            plan = CLR;
        else if (use_step)
            plan = dir_inc ? INC : DEC;
        else
            plan = LOAD;
    end
`else
    // target==0 with shadow==0 never reaches the plan: it is a done-only seek.
    always_comb plan = (req_index == '0) ? CLR : LOAD;
    assign cmd_inc = 1'b0;
    assign cmd_dec = 1'b0;
`endif

    // Command to strobe on the next cycle; NONE means no PULSE follows.
    always_comb begin
        fire = NONE;
        case (state)
            IDLE:    if (req_valid && req_index <= max_index && req_index != shadow) fire = plan;
            GAP:     if (gap_cnt == '0 && shadow != load_val) fire = cmd;
            default: fire = NONE;
        endcase
    end

    always_comb begin
        case (cmd)
            CLR:     shadow_nxt = '0;
            INC:     shadow_nxt = (shadow == max_q) ? '0 : shadow + 1'b1;
            DEC:     shadow_nxt = (shadow == '0) ? max_q : shadow - 1'b1;
            LOAD:    shadow_nxt = load_val;
            default: shadow_nxt = shadow;
        endcase
    end

    assign req_ready = (state == IDLE);

    always_ff @(posedge counter_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd      <= NONE;
            shadow   <= '0;
            load_val <= '0;
            max_q    <= '0;
            gap_cnt  <= '0;
            cmd_clr  <= 1'b0;
            cmd_load <= 1'b0;
`ifdef FLAG_SEEK_STEP_EN
            cmd_inc  <= 1'b0;
            cmd_dec  <= 1'b0;
`endif
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cmd_clr  <= (fire == CLR);
            cmd_load <= (fire == LOAD);
`ifdef FLAG_SEEK_STEP_EN
            cmd_inc  <= (fire == INC);
            cmd_dec  <= (fire == DEC);
`endif
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        load_val <= req_index;
                        max_q    <= max_index;
                        if (fire != NONE) begin
                            cmd   <= fire;
                            state <= PULSE;
                        end else begin
                            state <= FINISH;
                            err   <= (req_index > max_index);
                            done  <= (req_index <= max_index);
                        end
                    end
                end
                PULSE: begin
                    shadow  <= shadow_nxt;
                    gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (fire != NONE) begin
                        state <= PULSE;
                    end else begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_seek_driver.sv
// Scoreboard bench for flag_seek_driver: a ring-arithmetic model queues expected strobe/done/err
// events with their cycle, and a negedge monitor pops and compares whatever the DUT presents.
module tb_flag_seek_driver;

    localparam int GAP = 1;
    localparam int LIM = 4;
`ifdef FLAG_SEEK_STEP_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    logic       counter_clk = 1'b0;
    logic       rst_n       = 1'b0;
    logic       req_valid   = 1'b0;
    logic       req_ready;
    logic [6:0] req_index   = '0;
    logic [6:0] max_index   = '0;
    logic       cmd_clr, cmd_inc, cmd_dec, cmd_load;
    logic [6:0] load_val, shadow;
    logic       done, err;

    flag_seek_driver #(.IDX_W(7), .GAP_CYCLES(GAP), .STEP_LIMIT(LIM)) dut (
        .counter_clk (counter_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_index   (req_index),
        .max_index   (max_index),
        .cmd_clr     (cmd_clr),
        .cmd_inc     (cmd_inc),
        .cmd_dec     (cmd_dec),
        .cmd_load    (cmd_load),
        .load_val    (load_val),
        .shadow      (shadow),
        .done        (done),
        .err         (err)
    );

    always #5 counter_clk = ~counter_clk;

    // kind bits: {clr, inc, dec, load, done, err}
    localparam logic [5:0] K_CLR = 6'b100000, K_INC = 6'b010000, K_DEC = 6'b001000,
                           K_LOAD = 6'b000100, K_DONE = 6'b000010, K_ERR = 6'b000001;

    typedef struct {
        logic [5:0] kind;
        int         cyc;
        int         sh;
        int         lv;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  msh      = 0;
    bit  mon_off  = 1'b0;

    always @(posedge counter_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [5:0] k, input int c, input int sh, input int lv);
        ev_t e;
        e.kind = k; e.cyc = c; e.sh = sh; e.lv = lv;
        exp_q.push_back(e);
    endtask

    // Expected events for one accepted request, straight from the ring arithmetic.
    task automatic model(input int t, input int m, input int acc);
        int span, fwd, back, n, steps;
        span = m + 1;
        if (t > m) begin
            push(K_ERR, acc + 1, msh, t);
        end else if (t == msh) begin
            push(K_DONE, acc + 1, msh, t);
        end else begin
            n = 0;
            fwd  = (t - msh + span) % span;
            back = span - fwd;
            steps = (fwd <= back) ? fwd : back;
            if (t == 0) begin
                push(K_CLR, acc + 1, msh, t);
                msh = 0; n = 1;
            end else if (STEP && steps <= LIM) begin
                for (int i = 0; i < steps; i++) begin
                    push((fwd <= back) ? K_INC : K_DEC, acc + 1 + i * (1 + GAP), msh, t);
                    msh = (fwd <= back) ? (msh + 1) % span : (msh + span - 1) % span;
                end
                n = steps;
            end else begin
                push(K_LOAD, acc + 1, msh, t);
                msh = t; n = 1;
            end
            push(K_DONE, acc + 1 + n * (1 + GAP), msh, t);
        end
    endtask

    logic [5:0] mon_kind;
    ev_t        mon_e;

    always @(negedge counter_clk) begin
        if (rst_n && !mon_off) begin
            mon_kind = {cmd_clr, cmd_inc, cmd_dec, cmd_load, done, err};
            if (mon_kind != 6'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(mon_kind), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("event_shadow", 32'(shadow), mon_e.sh);
                    chk("event_load_val", 32'(load_val), mon_e.lv);
                    chk("busy_not_ready", 32'(req_ready), 32'd0);
                end
            end
        end
    end

    task automatic step_cycles(input int n);
        repeat (n) begin @(posedge counter_clk); #1; end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin step_cycles(1); n++; end
        if (req_ready !== 1'b1) chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic seek(input int t, input int m);
        wait_ready();
        req_valid = 1'b1; req_index = 7'(t); max_index = 7'(m);
        model(t, m, cyc);
        step_cycles(1);
        req_valid = 1'b0; req_index = 7'($urandom); max_index = 7'($urandom);
        wait_ready();
        step_cycles($urandom_range(0, 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t, m, pk;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_strobes", 32'({cmd_clr, cmd_inc, cmd_dec, cmd_load}), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_shadow", 32'(shadow), 32'd0);
        chk("rst_load_val", 32'(load_val), 32'd0);
        @(negedge counter_clk); rst_n = 1'b1;
        step_cycles(4);

        // Directed: step/load/clr/err/done-only scenarios on max=11.
        seek(3, 11); seek(1, 11); seek(10, 11); seek(0, 11); seek(6, 11);
        seek(12, 11); seek(6, 11); seek(5, 11); seek(0, 11);
        // Ring boundary at the widest index and span-1 ring.
        seek(127, 127); seek(0, 127); seek(126, 127); seek(1, 127);
        seek(0, 127); seek(0, 0); seek(2, 0);

        for (int i = 0; i < 60; i++) begin
            m = $urandom_range(msh, 20);
            t = ($urandom_range(0, 5) == 0) ? msh : $urandom_range(0, m + 2);
            seek(t, m);
        end

        // Reset in the middle of a strobe: it must drop at once and nothing may follow.
        seek(0, 11);
        wait_ready();
        mon_off = 1'b1;
        pk = STEP ? 3 : 1;
        req_valid = 1'b1; req_index = STEP ? 7'd3 : 7'd6; max_index = 7'd11; acc = cyc;
        step_cycles(1);
        req_valid = 1'b0;
        while (cyc < acc + pk) step_cycles(1);
        #1;
        chk("mid_strobe_high", 32'(STEP ? cmd_inc : cmd_load), 32'd1);
        if (STEP) chk("mid_shadow_before", 32'(shadow), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_strobes_low", 32'({cmd_clr, cmd_inc, cmd_dec, cmd_load}), 32'd0);
        chk("async_shadow", 32'(shadow), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd1);
        chk("async_done", 32'({done, err}), 32'd0);
        msh = 0;
        @(negedge counter_clk); @(negedge counter_clk);
        rst_n = 1'b1;
        mon_off = 1'b0;
        step_cycles(10);
        seek(2, 11);
        seek(9, 11);

        step_cycles(5);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
